// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction prefetch stage. Issues sequential word reads to an
//             instruction BRAM (1-cycle latency) and buffers the returned
//             words, tagged with their PCs, in a DEPTH-entry FIFO. The head
//             is presented to the core with a valid/ready handshake. A
//             redirect flushes the FIFO, discards any in-flight read and
//             restarts fetch at redirect_pc.
//  Ports    : clk          - clock, all state on rising edge
//             reset        - synchronous, active-low
//             imem_en      - BRAM read enable
//             imem_addr    - BRAM word address (current fetch PC)
//             imem_rdata   - BRAM read data, valid the cycle after imem_en
//             redirect     - flush and restart at redirect_pc
//             redirect_pc  - new fetch address
//             inst_valid   - head entry valid
//             inst_ready   - core accepts head this cycle
//             inst         - head instruction word
//             inst_pc      - address of head instruction
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int                      c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0]      c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]        c_CNT_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W+1:0]      c_DEPTH_W = (c_PTR_W + 2)'(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_pend_pc;
  logic               r_pending;
  logic [c_PTR_W:0]   r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [31:0]        r_buf_inst [DEPTH];
  logic [31:0]        r_buf_pc   [DEPTH];

  logic [c_PTR_W+1:0] w_occupancy;
  logic               w_issue;
  logic               w_enq;
  logic               w_deq;

  // Entries already held plus the read still in flight: a slot is reserved
  // at issue time so the returning word can never land in a full FIFO.
  assign w_occupancy = {1'b0, r_count} + {{(c_PTR_W + 1){1'b0}}, r_pending};
  assign w_issue     = reset & ~redirect & (w_occupancy < c_DEPTH_W);
  assign w_enq       = reset & ~redirect & r_pending;
  assign w_deq       = inst_valid & inst_ready;

  assign imem_en     = w_issue;
  assign imem_addr   = r_fetch_pc;

  // Redirect masks valid so no handshake can complete in the flush cycle.
  assign inst_valid  = reset & ~redirect & (r_count != '0);
  assign inst        = reset ? r_buf_inst[r_rd_ptr] : 32'h0;
  assign inst_pc     = reset ? r_buf_pc[r_rd_ptr]   : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= 32'h0;
      r_pending  <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_pending  <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd1;
        r_pend_pc  <= r_fetch_pc;
        r_pending  <= 1'b1;
      end else begin
        r_pending  <= 1'b0;
      end

      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_buf_inst[r_wr_ptr] <= imem_rdata;
      r_buf_pc[r_wr_ptr]   <= r_pend_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. Directed vector table,
//             randomized run against a queue-level reference model, and a
//             second instance exercising the 32-bit PC wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] B_RST_PC = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (RESET_PC = 0) ----------------
  logic        a_reset, a_redirect, a_ready;
  logic [31:0] a_redirect_pc;
  logic        a_en, a_valid;
  logic [31:0] a_addr, a_rdata, a_inst, a_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut_a (
    .clk(clk), .reset(a_reset),
    .imem_en(a_en), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .redirect(a_redirect), .redirect_pc(a_redirect_pc),
    .inst_valid(a_valid), .inst_ready(a_ready),
    .inst(a_inst), .inst_pc(a_pc)
  );

  // ---------------- instance B (RESET_PC near wrap) ----------------
  logic        b_reset, b_redirect, b_ready;
  logic [31:0] b_redirect_pc;
  logic        b_en, b_valid;
  logic [31:0] b_addr, b_rdata, b_inst, b_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(B_RST_PC)) u_dut_b (
    .clk(clk), .reset(b_reset),
    .imem_en(b_en), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc),
    .inst_valid(b_valid), .inst_ready(b_ready),
    .inst(b_inst), .inst_pc(b_pc)
  );

  function automatic logic [31:0] bram_word(input logic [31:0] addr);
    return 32'hA000_0000 + addr;
  endfunction

  // BRAM models: one-cycle registered read
  always @(posedge clk) if (a_en) a_rdata <= bram_word(a_addr);
  always @(posedge clk) if (b_en) b_rdata <= bram_word(b_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic av(input logic rst_n, input logic redir, input logic [31:0] rpc,
                    input logic rdy, input logic en, input logic [31:0] addr,
                    input logic v, input logic [31:0] pc);
    vec_t t;
    t.rst_n = rst_n; t.redir = redir; t.rpc = rpc; t.rdy = rdy;
    t.en = en; t.addr = addr; t.v = v; t.pc = pc;
    vecs.push_back(t);
  endtask

  // ---------------- reference model state (instance A) ----------------
  logic [31:0] m_q[$];
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fetch_pc;

  initial begin
    logic        exp_en, exp_v;
    int          hs;
    int          k;
    logic [31:0] exp_pc;

    a_reset = 1'b0; a_redirect = 1'b0; a_redirect_pc = 32'h0; a_ready = 1'b1;
    b_reset = 1'b0; b_redirect = 1'b0; b_redirect_pc = 32'h0; b_ready = 1'b1;

    //   rst redir rpc      rdy  en  addr     v  pc
    av(0, 0, 32'h0,  1,  0, 32'h0,  0, 32'h0);   // reset
    av(0, 0, 32'h0,  1,  0, 32'h0,  0, 32'h0);
    av(1, 0, 32'h0,  1,  1, 32'h0,  0, 32'h0);   // release, issue 0
    av(1, 0, 32'h0,  1,  1, 32'h1,  0, 32'h0);
    av(1, 0, 32'h0,  1,  1, 32'h2,  1, 32'h0);   // first valid 2 cycles after release
    av(1, 0, 32'h0,  1,  1, 32'h3,  1, 32'h1);
    av(1, 0, 32'h0,  1,  1, 32'h4,  1, 32'h2);   // read of 4 goes in flight
    av(1, 1, 32'h40, 1,  0, 32'h0,  0, 32'h0);   // redirect+ready while head valid
    av(1, 0, 32'h0,  1,  1, 32'h40, 0, 32'h0);   // flushed: empty
    av(1, 0, 32'h0,  1,  1, 32'h41, 0, 32'h0);
    av(1, 0, 32'h0,  1,  1, 32'h42, 1, 32'h40);  // 3 invalid cycles then 0x40
    av(1, 0, 32'h0,  1,  1, 32'h43, 1, 32'h41);
    av(1, 0, 32'h0,  0,  1, 32'h44, 1, 32'h42);  // stall: fill up
    av(1, 0, 32'h0,  0,  1, 32'h45, 1, 32'h42);
    av(1, 0, 32'h0,  0,  0, 32'h0,  1, 32'h42);  // reservation full
    av(1, 0, 32'h0,  0,  0, 32'h0,  1, 32'h42);  // FIFO full, head stable
    av(1, 0, 32'h0,  1,  0, 32'h0,  1, 32'h42);
    av(1, 0, 32'h0,  1,  1, 32'h46, 1, 32'h43);  // slot frees, fetch resumes
    av(0, 0, 32'h0,  1,  0, 32'h0,  0, 32'h0);   // reset mid-stream
    av(1, 0, 32'h0,  1,  1, 32'h0,  0, 32'h0);   // restart at RESET_PC
    av(1, 0, 32'h0,  1,  1, 32'h1,  0, 32'h0);
    av(1, 0, 32'h0,  1,  1, 32'h2,  1, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      a_reset = vecs[i].rst_n; a_redirect = vecs[i].redir;
      a_redirect_pc = vecs[i].rpc; a_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d imem_en", i), {31'h0, a_en}, {31'h0, vecs[i].en});
      if (vecs[i].en) chk($sformatf("vec%0d imem_addr", i), a_addr, vecs[i].addr);
      chk($sformatf("vec%0d inst_valid", i), {31'h0, a_valid}, {31'h0, vecs[i].v});
      if (vecs[i].v) begin
        chk($sformatf("vec%0d inst_pc", i), a_pc, vecs[i].pc);
        chk($sformatf("vec%0d inst", i), a_inst, bram_word(vecs[i].pc));
      end
      if (!vecs[i].rst_n) begin
        chk($sformatf("vec%0d inst_rst", i), a_inst, 32'h0);
        chk($sformatf("vec%0d pc_rst", i), a_pc, 32'h0);
      end
    end

    // ---------------- randomized run against reference model ----------------
    m_q.delete(); m_pend = 1'b0; m_pend_pc = 32'h0; m_fetch_pc = 32'h0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a_reset       = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      a_redirect    = ($urandom_range(0, 19) == 0);
      a_redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                  : $urandom;
      a_ready       = ($urandom_range(0, 3) != 0);
      #1;
      exp_en = a_reset && !a_redirect && ((m_q.size() + int'(m_pend)) < DEPTH);
      exp_v  = a_reset && !a_redirect && (m_q.size() > 0);
      chk("rnd imem_en", {31'h0, a_en}, {31'h0, exp_en});
      if (exp_en) chk("rnd imem_addr", a_addr, m_fetch_pc);
      chk("rnd inst_valid", {31'h0, a_valid}, {31'h0, exp_v});
      if (exp_v) begin
        chk("rnd inst_pc", a_pc, m_q[0]);
        chk("rnd inst", a_inst, bram_word(m_q[0]));
      end
      if (!a_reset) begin
        chk("rnd inst_rst", a_inst, 32'h0);
        chk("rnd pc_rst", a_pc, 32'h0);
      end
      @(posedge clk);
      if (!a_reset) begin
        m_q.delete(); m_pend = 1'b0; m_fetch_pc = 32'h0;
      end else if (a_redirect) begin
        m_q.delete(); m_pend = 1'b0; m_fetch_pc = a_redirect_pc;
      end else begin
        if (exp_v && a_ready) void'(m_q.pop_front());
        if (m_pend) m_q.push_back(m_pend_pc);
        if (exp_en) begin
          m_pend_pc  = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd1;
          m_pend     = 1'b1;
        end else begin
          m_pend = 1'b0;
        end
      end
    end

    // ---------------- PC wrap on instance B ----------------
    @(negedge clk);
    b_reset = 1'b0;
    @(negedge clk);
    b_reset = 1'b1;
    hs = 0; k = 0; exp_pc = B_RST_PC;
    while (hs < 24 && k < 300) begin
      if (k > 0) @(negedge clk);
      b_ready = (hs < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (k < 2) chk("wrap early valid", {31'h0, b_valid}, 32'h0);
      else if (hs < 4) chk("wrap stream valid", {31'h0, b_valid}, 32'h1);
      if (b_valid && b_ready) begin
        chk("wrap inst_pc", b_pc, exp_pc);
        chk("wrap inst", b_inst, bram_word(exp_pc));
        exp_pc = exp_pc + 32'd1;
        hs++;
      end
      @(posedge clk);
      k++;
    end
    chk("wrap handshake count", 32'(hs), 32'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
